serial_chunk_adder: RTL

Multi-cycle parametrised adder: computes a + b + cin on WIDTH-bit operands by processing one CHUNK-bit slice per clock, LSB slice first, with a registered carry between slices. It is the sequential, width-generalised successor to the team's single-bit half adder. It trades latency for a narrow carry chain. Valid/ready handshakes sit on both the input and the output side, so it drops into streaming datapaths.

---
 rtl/serial_chunk_adder.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_chunk_adder.sv
// Multi-cycle a+b+cin adder: one CHUNK-bit slice per clock, LSB first,
// with valid/ready handshakes on operand and result sides.
module serial_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             c;
   logic [IW-1:0]    idx;
   logic             last;
   int               base;
   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic [CHUNK-1:0] s_sl;
   logic             c_nx;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   assign last = (idx == IW'(N - 1));
   assign base = int'(idx) * CHUNK;
   assign a_sl = a_r[base +: CHUNK];
   assign b_sl = b_r[base +: CHUNK];

   // one extra bit on the slice add carries into the next slice
   assign {c_nx, s_sl} = {1'b0, a_sl} + {1'b0, b_sl}
                       + (CHUNK + 1)'(c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r  <= '0;
         b_r  <= '0;
         c    <= 1'b0;
         idx  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r <= a;
                  b_r <= b;
                  c   <= cin;
                  idx <= '0;
                  sum <= '0;
               end
            end
            RUN: begin
               sum[base +: CHUNK] <= s_sl;
               c   <= c_nx;
               idx <= idx + 1'b1;
               // top slice holds the operand and result sign bits
               if (last) begin
                  cout <= c_nx;
                  ovf  <= (a_sl[CHUNK-1] == b_sl[CHUNK-1])
                       && (s_sl[CHUNK-1] != a_sl[CHUNK-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
